ysyx_22041412_ifu: RTL
======================

YSYX_22041412_IFU -- requirements
Module: ysyx_22041412_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req_valid  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_req_addr  output  32  request address, equal to the current PC.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_rsp_valid  input  1  response data valid, one cycle per accepted request.
REQ-008 SHALL have port imem_rsp_data  input  32  fetched instruction word.
REQ-009 SHALL have port jal_ok  input  1  decode-stage JAL redirect strobe.
REQ-010 SHALL have port jal_pc  input  64  JAL target; bits [31:0] are used.
REQ-011 SHALL have port ex_redirect  input  1  execute-stage branch/JALR redirect strobe.
REQ-012 SHALL have port ex_pc  input  64  execute redirect target; bits [31:0] are used.
REQ-013 SHALL have port out_valid  output  1  instr/pc pair valid toward decode.
REQ-014 SHALL have port out_ready  input  1  decode accepts the pair.
REQ-015 SHALL have port out_instr  output  32  fetched instruction.
REQ-016 SHALL have port out_pc  output  32  PC of out_instr.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, HOLD; REQ drives imem_req_valid=1; WAIT and HOLD drive 0.
REQ-018 SHALL move REQ->WAIT when imem_req_valid&&imem_req_ready, capturing the request PC.
REQ-019 SHALL, in WAIT on imem_rsp_valid, load out_instr/out_pc, assert out_valid next cycle, and go to HOLD.
REQ-020 SHALL, in HOLD, keep out_valid, out_instr and out_pc stable until out_ready=1; on the handshake it SHALL set PC=out_pc+4 and go to REQ, which gives a 3-cycle minimum issue-to-issue interval.
REQ-021 SHALL add PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 SHALL prioritise ex_redirect over jal_ok when both are asserted in the same cycle.
REQ-023 SHALL, on a redirect in REQ, set PC to the target and stay in REQ; a request accepted in that same cycle SHALL be treated as stale.
REQ-024 SHALL, on a redirect in WAIT, set PC to the target and set a drop flag; the pending response SHALL be discarded (out_valid stays 0) and the FSM SHALL return to REQ.
REQ-025 SHALL, on a redirect in HOLD, deassert out_valid next cycle, set PC to the target and go to REQ; any simultaneous out_ready is ignored.
REQ-026 SHALL ignore imem_rsp_valid outside WAIT.
REQ-027 SHALL have no combinational path from any input to out_valid, out_instr or out_pc.

Reset
REQ-028 SHALL, while rst=1, set PC=RESET_PC, state=REQ, out_valid=0, out_instr=0, out_pc=0, drop flag=0 and imem_req_valid=0.
REQ-029 SHALL treat rst asserted mid-transaction (WAIT or HOLD) as aborting it; a response arriving after reset deasserts SHALL be discarded via the drop flag set by reset.
REQ-030 SHALL issue the first request (imem_req_addr=RESET_PC) on the first cycle after rst deasserts.

Configuration
REQ-031 SHALL, when YSYX_22041412_IFU_ALIGN_CHECK_EN is defined, add output misalign (1 bit); a redirect target with bits [1:0]!=0 SHALL not be fetched, and the block SHALL instead present out_valid=1, out_instr=32'h0000_0013 (NOP), out_pc=target, misalign=1 in HOLD.
REQ-032 SHALL, when YSYX_22041412_IFU_ALIGN_CHECK_EN is undefined, omit the misalign port and force target bits [1:0] to 0.

Verification
REQ-033 SHALL cover: reset release, ready=1, rsp 1 cycle later, out_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 issued in order.
REQ-034 SHALL cover: out_ready=0 for 5 cycles in HOLD -> out_valid, out_instr and out_pc unchanged, no new imem_req_valid.
REQ-035 SHALL cover: ex_redirect=1 with ex_pc=0x80000100 in WAIT -> stale response dropped, next request addr=0x80000100.
REQ-036 SHALL cover: jal_ok (jal_pc=0x80000040) and ex_redirect (ex_pc=0x80000200) in the same cycle -> next request addr=0x80000200.
REQ-037 SHALL cover: PC=0xFFFFFFFC consumed -> next request addr=0x00000000.
REQ-038 SHALL cover: with YSYX_22041412_IFU_ALIGN_CHECK_EN defined, ex_pc=0x80000102 -> misalign=1, out_pc=0x80000102, no imem request for that address.

Source files
------------

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: REQ/WAIT/HOLD fetch FSM with decode/execute redirects.
// Optional YSYX_22041412_IFU_ALIGN_CHECK_EN reports misaligned redirect targets.
module ysyx_22041412_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        jal_ok,
  input  logic [63:0] jal_pc,
  input  logic        ex_redirect,
  input  logic [63:0] ex_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_pc, req_pc_n;
  logic        out_valid_n;
  logic [31:0] out_instr_n, out_pc_n;
  // Drop flag is drop_cnt != 0: responses still owed for requests that went stale.
  logic [1:0]  drop_cnt, drop_n;
  // Responses owed for requests aborted by reset, carried across the reset.
  logic [1:0]  rst_owed, rst_owed_n;
  logic [2:0]  drop_sum, owed_sum;
  logic        stale_add;
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
  logic        misalign_n;
`endif

  logic        redirect;
  logic [31:0] target_raw, target;
  logic        owe_stale, rsp_stale, rsp_live, req_fire;
  logic        unused_ok;

  assign redirect   = ex_redirect | jal_ok;
  assign target_raw = ex_redirect ? ex_pc[31:0] : jal_pc[31:0];
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
  assign target     = target_raw;
  assign unused_ok  = ^{jal_pc[63:32], ex_pc[63:32]};
`else
  assign target     = {target_raw[31:2], 2'b00};
  assign unused_ok  = ^{jal_pc[63:32], ex_pc[63:32], target_raw[1:0]};
`endif

  assign owe_stale = (drop_cnt != 2'd0) || (rst_owed != 2'd0);
  assign rsp_stale = imem_rsp_valid && owe_stale;
  assign rsp_live  = imem_rsp_valid && !owe_stale;

  // Issue is held off only if the stale-response counter is saturated.
  assign imem_req_valid = !rst && (state == S_REQ) && (drop_cnt != 2'd3);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_n     = state;
    pc_n        = pc;
    req_pc_n    = req_pc;
    out_valid_n = out_valid;
    out_instr_n = out_instr;
    out_pc_n    = out_pc;
    stale_add   = 1'b0;
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
    misalign_n  = misalign;
`endif

    unique case (state)
      S_REQ: begin
        if (redirect) begin
          pc_n      = target;
          stale_add = req_fire;
        end else if (req_fire) begin
          req_pc_n = pc;
          state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // A live response in the same cycle is simply discarded; otherwise it is owed.
          pc_n      = target;
          state_n   = S_REQ;
          stale_add = !rsp_live;
        end else if (rsp_live) begin
          out_valid_n = 1'b1;
          out_instr_n = imem_rsp_data;
          out_pc_n    = req_pc;
          state_n     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          out_valid_n = 1'b0;
          pc_n        = target;
          state_n     = S_REQ;
        end else if (out_ready) begin
          out_valid_n = 1'b0;
          pc_n        = out_pc + 32'd4;
          state_n     = S_REQ;
        end
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
        if (redirect || out_ready) misalign_n = 1'b0;
`endif
      end
      default: state_n = S_REQ;
    endcase

`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
    // A misaligned target is never fetched; a NOP carrying the target PC is presented.
    if (redirect && (target[1:0] != 2'b00)) begin
      state_n     = S_HOLD;
      out_valid_n = 1'b1;
      out_instr_n = NOP;
      out_pc_n    = target;
      misalign_n  = 1'b1;
    end
`endif

    drop_sum = {1'b0, drop_cnt} + {1'b0, rst_owed} + {2'b00, stale_add} - {2'b00, rsp_stale};
    drop_n   = (drop_sum > 3'd3) ? 2'd3 : drop_sum[1:0];

    // During reset: count the outstanding response of an aborted WAIT, minus arrivals.
    owed_sum = {1'b0, rst_owed} + {1'b0, drop_cnt} + {2'b00, state == S_WAIT};
    if (imem_rsp_valid && (owed_sum != 3'd0)) owed_sum = owed_sum - 3'd1;
    rst_owed_n = (owed_sum > 3'd3) ? 2'd3 : owed_sum[1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      req_pc    <= 32'd0;
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_pc    <= 32'd0;
      drop_cnt  <= 2'd0;
      rst_owed  <= rst_owed_n;
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_pc    <= req_pc_n;
      out_valid <= out_valid_n;
      out_instr <= out_instr_n;
      out_pc    <= out_pc_n;
      drop_cnt  <= drop_n;
      rst_owed  <= 2'd0;
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
      misalign  <= misalign_n;
`endif
    end
  end

endmodule
